// File: rtl/pipe_ctrl.sv
// Execution-stage issue/hazard controller: scoreboard, bubble insertion, branch flush.
// Optional feature macro: PIPE_CTRL_FWD_EN (with EX->EX forwarding only loads block readers).
module pipe_ctrl #(
    parameter int NREG         = 8,
    parameter int AW           = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rd_addr,
    input  logic [AW-1:0]   id_rs_addr,
    input  logic            id_use_rd,
    input  logic            id_use_rs,
    input  logic            id_wb,
    input  logic            id_is_ld,
    input  logic            ex_pc_w,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_addr,
    output logic            id_stall,
    output logic            ex_valid,
    output logic            flush_o,
    output logic [NREG-1:0] busy,
    output logic [1:0]      state,
    output logic [15:0]     stall_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

    state_t          cur;
    state_t          nxt;
    logic [3:0]      fcnt;
    logic [3:0]      fcnt_nxt;
    logic            flush_nxt;
    logic [15:0]     cnt_nxt;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] eff_busy;
    logic            hazard;
    logic            take;
    logic            issue;
    logic            sets_busy;

`ifdef PIPE_CTRL_FWD_EN
    assign sets_busy = id_is_ld;
`else
    // every writer blocks its readers until writeback, loads included
    assign sets_busy = id_is_ld | 1'b1;
`endif

    assign clr_vec  = wb_we ? (ONE << wb_addr) : '0;
    assign eff_busy = busy & ~clr_vec;

    assign hazard = (id_use_rd & eff_busy[id_rd_addr])
                  | (id_use_rs & eff_busy[id_rs_addr])
                  | (id_wb     & eff_busy[id_rd_addr]);

    assign take     = ex_valid & ex_pc_w;
    assign issue    = id_valid & ~hazard & ~take & (cur != FLUSH);
    assign id_stall = id_valid & ~issue;

    assign set_vec = (issue & id_wb & sets_busy) ? (ONE << id_rd_addr) : '0;
    assign state   = cur;

    always_comb begin
        nxt       = cur;
        fcnt_nxt  = fcnt;
        flush_nxt = 1'b0;
        cnt_nxt   = stall_cnt;
        unique case (cur)
            RUN, STALL: begin
                if (take) begin
                    nxt       = FLUSH;
                    flush_nxt = 1'b1;
                    fcnt_nxt  = 4'(FLUSH_CYCLES - 1);
                end else if (id_valid && hazard) begin
                    nxt = STALL;
                    if (stall_cnt != 16'hFFFF)
                        cnt_nxt = stall_cnt + 16'd1;
                end else begin
                    nxt = RUN;
                end
            end
            FLUSH: begin
                if (fcnt == 4'd0) begin
                    nxt = RUN;
                end else begin
                    flush_nxt = 1'b1;
                    fcnt_nxt  = fcnt - 4'd1;
                end
            end
            default: begin
                nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= RUN;
            fcnt      <= 4'd0;
            flush_o   <= 1'b0;
            stall_cnt <= 16'd0;
            ex_valid  <= 1'b0;
            busy      <= '0;
        end else begin
            cur       <= nxt;
            fcnt      <= fcnt_nxt;
            flush_o   <= flush_nxt;
            stall_cnt <= cnt_nxt;
            ex_valid  <= issue;
            busy      <= (busy & ~clr_vec) | set_vec;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
// Expected values are hand-derived per vector.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_use_rd, id_use_rs, id_wb, id_is_ld;
    logic [2:0]  id_rd_addr, id_rs_addr, wb_addr;
    logic        ex_pc_w, wb_we;
    logic        id_stall, ex_valid, flush_o;
    logic [7:0]  busy;
    logic [1:0]  state;
    logic [15:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rd_addr(id_rd_addr),
        .id_rs_addr(id_rs_addr), .id_use_rd(id_use_rd),
        .id_use_rs(id_use_rs), .id_wb(id_wb),
        .id_is_ld(id_is_ld), .ex_pc_w(ex_pc_w),
        .wb_we(wb_we), .wb_addr(wb_addr),
        .id_stall(id_stall), .ex_valid(ex_valid),
        .flush_o(flush_o), .busy(busy),
        .state(state), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_use_rd = 0; id_use_rs = 0;
        id_wb = 0; id_is_ld = 0; ex_pc_w = 0; wb_we = 0;
        id_rd_addr = 0; id_rs_addr = 0; wb_addr = 0;
    endtask

    task automatic wr(input logic [2:0] rd, input logic ld);
        idle();
        id_valid = 1; id_wb = 1; id_rd_addr = rd; id_is_ld = ld;
    endtask

    task automatic rd_rs(input logic [2:0] rs);
        idle();
        id_valid = 1; id_use_rs = 1; id_rs_addr = rs;
    endtask

    initial begin
        idle();
        rst = 1;
        tick(); tick();
        check("rst_exv", ex_valid, 0);
        check("rst_flush", flush_o, 0);
        check("rst_busy", busy, 0);
        check("rst_state", state, 0);
        check("rst_cnt", stall_cnt, 0);

        // load r5
        rst = 0;
        wr(3'd5, 1);
        #1 check("t1_stall", id_stall, 0);
        tick();
        check("t1_exv", ex_valid, 1);
        check("t1_busy", busy, 8'h20);

        // retire r5 while reissuing writer of r5: set wins
        wr(3'd5, 1);
        wb_we = 1; wb_addr = 3'd5;
        #1 check("t4_stall", id_stall, 0);
        tick();
        check("t4_busy", busy, 8'h20);
        check("t4_exv", ex_valid, 1);

        idle();
        wb_we = 1; wb_addr = 3'd5;
        tick();
        check("clr_busy", busy, 0);
        check("clr_exv", ex_valid, 0);

        // load-use stall on r3
        wr(3'd3, 1);
        tick();
        check("t2_busy", busy, 8'h08);
        rd_rs(3'd3);
        #1 check("t2_stall", id_stall, 1);
        tick();
        check("t2_state", state, 1);
        check("t2_cnt1", stall_cnt, 1);
        check("t2_exv", ex_valid, 0);
        tick();
        check("t2_cnt2", stall_cnt, 2);
        wb_we = 1; wb_addr = 3'd3;
        #1 check("t2_bypass", id_stall, 0);
        tick();
        check("t2_exv2", ex_valid, 1);
        check("t2_busy2", busy, 0);
        check("t2_state2", state, 0);
        check("t2_cnt3", stall_cnt, 2);

        // taken branch in EX
        rd_rs(3'd1);
        ex_pc_w = 1;
        #1 check("t3_stall0", id_stall, 1);
        tick();
        check("t3_fl1", flush_o, 1);
        check("t3_st1", state, 2);
        check("t3_exv1", ex_valid, 0);
        #1 check("t3_stall1", id_stall, 1);
        tick();
        check("t3_fl2", flush_o, 1);
        check("t3_st2", state, 2);
        check("t3_exv2", ex_valid, 0);
        tick();
        check("t3_fl3", flush_o, 0);
        check("t3_st3", state, 0);
        check("t3_exv3", ex_valid, 0);
        ex_pc_w = 0;
        #1 check("t3_stall3", id_stall, 0);
        tick();
        check("t3_exv4", ex_valid, 1);
        check("t3_cnt", stall_cnt, 2);

        // ALU writer r2 then reader r2
        wr(3'd2, 0);
        tick();
        rd_rs(3'd2);
`ifdef PIPE_CTRL_FWD_EN
        #1 check("t5_stall", id_stall, 0);
        tick();
        check("t5_exv", ex_valid, 1);
`else
        #1 check("t5_stall", id_stall, 1);
        tick();
        check("t5_exv", ex_valid, 0);
        check("t5_state", state, 1);
        wb_we = 1; wb_addr = 3'd2;
        #1 check("t5_release", id_stall, 0);
        tick();
        check("t5_exv2", ex_valid, 1);
        check("t5_cnt", stall_cnt, 3);
`endif

        // WAW hazard on busy r6
        wr(3'd6, 1);
        tick();
        wr(3'd6, 1);
        #1 check("waw_stall", id_stall, 1);
        wb_we = 1; wb_addr = 3'd6;
        #1 check("waw_bypass", id_stall, 0);
        tick();
        check("waw_busy", busy, 8'h40);

        // saturation on a long stall against r7
        wr(3'd7, 1);
        tick();
        rd_rs(3'd7);
        for (int i = 0; i < 65600; i++) begin
            @(posedge clk);
        end
        #1;
        check("t6_cnt", stall_cnt, 16'hFFFF);
        check("t6_state", state, 1);
        tick();
        check("t6_hold", stall_cnt, 16'hFFFF);

        // async reset mid-stall
        #2 rst = 1;
        #1;
        check("t1_rst_exv", ex_valid, 0);
        check("t1_rst_busy", busy, 0);
        check("t1_rst_state", state, 0);
        check("t1_rst_cnt", stall_cnt, 0);
        check("t1_rst_fl", flush_o, 0);
        tick();
        rst = 0;
        rd_rs(3'd7);
        #1 check("t1_rel_stall", id_stall, 0);
        tick();
        check("t1_rel_exv", ex_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
